regfile_write_sequencer: RTL and testbench

Clocked front-end that sits directly upstream of the 4-entry `register_file`. It accepts write/read commands over a valid/ready handshake and buffers them in a small FIFO. It turns each write into a clean single-cycle falling strobe on the register file's `write_enable`, and returns each read as a response with its own valid/ready handshake. It is the only block that drives the register file's `sel`, `data_in` and `write_enable`.

---
 rtl/regfile_write_sequencer.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_write_sequencer
//
// Front-end for a 4-entry register file. It queues write and read commands in
// a small FIFO and executes them strictly in order. Each write becomes one
// clean single-cycle low pulse on write_enable, with sel and data held stable
// on both sides of the pulse. Each read forces a sel transition so the
// register file refreshes data_out. The sampled value is then returned with a
// valid/ready response handshake.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready = FIFO not full)
//   cmd_write             1 = write, 0 = read
//   cmd_sel, cmd_data     target register and write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_data, rsp_sel     read value and the register it came from
//   rf_sel, rf_data_in    register file select and write data
//   rf_write_enable       register file write enable; idles high
//   rf_data_out           register file read data
//   busy                  FSM active or commands still queued
// -----------------------------------------------------------------------------
module regfile_write_sequencer #(
   parameter int INPUT_SIZE = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [1:0]            cmd_sel,
   input  logic [INPUT_SIZE-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [INPUT_SIZE-1:0] rsp_data,
   output logic [1:0]            rsp_sel,
   output logic [1:0]            rf_sel,
   output logic [INPUT_SIZE-1:0] rf_data_in,
   output logic                  rf_write_enable,
   input  logic [INPUT_SIZE-1:0] rf_data_out,
   output logic                  busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE, W_SETUP, W_STROBE, W_HOLD, R_ALT, R_SEL, R_RESP
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [1:0]            sel;
      logic [INPUT_SIZE-1:0] data;
   } cmd_t;

   // ---------------------------------------------------------------- FIFO
   cmd_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   logic             empty;
   cmd_t             head;
   cmd_t             cmd_in;

   state_t state_q;
   state_t state_d;
   logic [1:0] rd_sel;  // register targeted by the read in progress

   assign empty     = (count == '0);
   assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE) && !empty;
   assign head      = fifo_mem[rd_ptr];
   assign cmd_in    = '{write: cmd_write, sel: cmd_sel, data: cmd_data};
   assign busy      = (state_q != IDLE) || !empty;

   // NOTE: FIFO storage is deliberately not reset; an entry is only read
   // after it has been written, so a reset here would only cost logic.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (!empty) state_d = head.write ? W_SETUP : R_ALT;
         W_SETUP:  state_d = W_STROBE;
         W_STROBE: state_d = W_HOLD;
         W_HOLD:   state_d = IDLE;
         R_ALT:    state_d = R_SEL;
         R_SEL:    state_d = R_RESP;
         R_RESP:   if (rsp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------- datapath
   // write_enable is registered rather than decoded from the state so the
   // register file sees a glitch-free strobe. Reset forces it high at once,
   // which is a rising edge and therefore never a spurious capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_write_enable <= 1'b1;
         rf_sel          <= '0;
         rf_data_in      <= '0;
         rd_sel          <= '0;
         rsp_valid       <= 1'b0;
         rsp_data        <= '0;
         rsp_sel         <= '0;
      end else begin
         rf_write_enable <= (state_d != W_STROBE);
         case (state_q)
            IDLE: begin
               if (pop) begin
                  rd_sel <= head.sel;
                  if (head.write) begin
                     rf_sel     <= head.sel;
                     rf_data_in <= head.data;
                  end else begin
                     // Move sel away first so the return to the target is
                     // a real transition and data_out is refreshed.
                     rf_sel <= ~head.sel;
                  end
               end
            end
            R_ALT: rf_sel <= rd_sel;
            R_SEL: begin
               rsp_data  <= rf_data_out;
               rsp_sel   <= rd_sel;
               rsp_valid <= 1'b1;
            end
            R_RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_sequencer
//
// Directed bench for regfile_write_sequencer. A behavioural 4-entry register
// file sits behind the DUT: it captures data_in into regs[sel] on the falling
// edge of write_enable and refreshes data_out only when sel changes.
// -----------------------------------------------------------------------------
module tb_regfile_write_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [1:0] cmd_sel = 2'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic [1:0] rsp_sel;
   logic [1:0] rf_sel;
   logic [7:0] rf_data_in;
   logic       rf_write_enable;
   logic [7:0] rf_data_out = 8'd0;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int strobes = 0;

   logic [7:0] regs [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

   regfile_write_sequencer #(.INPUT_SIZE(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_sel(rsp_sel),
      .rf_sel(rf_sel), .rf_data_in(rf_data_in),
      .rf_write_enable(rf_write_enable), .rf_data_out(rf_data_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Register file model.
   always @(negedge rf_write_enable) begin
      strobes++;
      regs[rf_sel] = rf_data_in;
   end
   always @(rf_sel) rf_data_out = regs[rf_sel];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic w, input logic [1:0] s, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = s;
      cmd_data  = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         step();
         n++;
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      total += 8;
      if (cmd_ready !== 1'b1)       begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      if (rsp_valid !== 1'b0)       begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      if (rsp_data !== 8'd0)        begin bad++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
      if (rsp_sel !== 2'd0)         begin bad++; $display("FAIL reset_rsp_sel: got %0d want 0", rsp_sel); end
      if (rf_sel !== 2'd0)          begin bad++; $display("FAIL reset_rf_sel: got %0d want 0", rf_sel); end
      if (rf_data_in !== 8'd0)      begin bad++; $display("FAIL reset_rf_data_in: got %0d want 0", rf_data_in); end
      if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL reset_we: got %b want 1", rf_write_enable); end
      if (busy !== 1'b0)            begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_single_write();
      int s0 = strobes;
      push(1'b1, 2'd0, 8'd42);                      // E0
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_e0: got %b want 1", busy); end
      step();                                        // E1
      total += 3;
      if (rf_sel !== 2'd0)          begin bad++; $display("FAIL wr_sel_e1: got %0d want 0", rf_sel); end
      if (rf_data_in !== 8'd42)     begin bad++; $display("FAIL wr_data_e1: got %0d want 42", rf_data_in); end
      if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL wr_we_e1: got %b want 1", rf_write_enable); end
      step();                                        // E2
      total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL wr_we_e2: got %b want 0", rf_write_enable); end
      step();                                        // E3
      total += 2;
      if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL wr_we_e3: got %b want 1", rf_write_enable); end
      if (busy !== 1'b1)            begin bad++; $display("FAIL wr_busy_e3: got %b want 1", busy); end
      step();                                        // E4
      total += 4;
      if (busy !== 1'b0)            begin bad++; $display("FAIL wr_busy_e4: got %b want 0", busy); end
      if (rf_data_in !== 8'd42)     begin bad++; $display("FAIL wr_data_hold: got %0d want 42", rf_data_in); end
      if (regs[0] !== 8'd42)        begin bad++; $display("FAIL wr_rf_a: got %0d want 42", regs[0]); end
      if (strobes - s0 !== 1)       begin bad++; $display("FAIL wr_strobe_count: got %0d want 1", strobes - s0); end
   endtask

   task automatic test_read_after_write();
      push(1'b1, 2'd1, 8'd13);
      wait_idle("raw_write_idle");
      total++; if (rf_sel !== 2'd1) begin bad++; $display("FAIL raw_sel_before: got %0d want 1", rf_sel); end
      rsp_ready = 1'b0;
      push(1'b0, 2'd1, 8'hFF);                       // E0 (data ignored)
      step();                                        // E1
      total++; if (rf_sel !== 2'd2) begin bad++; $display("FAIL raw_sel_alt: got %0d want 2", rf_sel); end
      step();                                        // E2
      total += 2;
      if (rf_sel !== 2'd1)    begin bad++; $display("FAIL raw_sel_back: got %0d want 1", rf_sel); end
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL raw_valid_early: got %b want 0", rsp_valid); end
      step();                                        // E3
      total += 4;
      if (rsp_valid !== 1'b1)       begin bad++; $display("FAIL raw_valid: got %b want 1", rsp_valid); end
      if (rsp_data !== 8'd13)       begin bad++; $display("FAIL raw_data: got %0d want 13", rsp_data); end
      if (rsp_sel !== 2'd1)         begin bad++; $display("FAIL raw_rsp_sel: got %0d want 1", rsp_sel); end
      if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL raw_we: got %b want 1", rf_write_enable); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL raw_valid_drop: got %b want 0", rsp_valid); end
   endtask

   task automatic test_fifo_full();
      logic [1:0] seq      [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] exp_data [5] = '{8'd42, 8'd13, 8'h55, 8'hAA, 8'd42};
      logic [1:0] got_sel  [5];
      logic [7:0] got_data [5];
      int got = 0;
      int n = 0;
      push(1'b1, 2'd2, 8'h55);
      push(1'b1, 2'd3, 8'hAA);
      wait_idle("full_prefill_idle");
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_sel = seq[i];
         step();
      end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_3: got %b want 1", cmd_ready); end
      cmd_sel = seq[4];
      step();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready_4: got %b want 0", cmd_ready); end
      cmd_sel = 2'd1;                                // 6th push, must be refused
      for (int i = 0; i < 3; i++) begin
         step();
         total += 2;
         if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_blocked_%0d: cmd_ready=%b want 0", i, cmd_ready); end
         if (rsp_sel !== 2'd0)   begin bad++; $display("FAIL full_head_%0d: rsp_sel=%0d want 0", i, rsp_sel); end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      while (got < 5 && n < 60) begin
         if (rsp_valid === 1'b1) begin
            got_sel[got]  = rsp_sel;
            got_data[got] = rsp_data;
            got++;
         end
         step();
         n++;
      end
      total++; if (got !== 5) begin bad++; $display("FAIL full_rsp_count: got %0d want 5", got); end
      for (int i = 0; i < got; i++) begin
         total += 2;
         if (got_sel[i] !== seq[i])       begin bad++; $display("FAIL full_order_%0d: sel=%0d want %0d", i, got_sel[i], seq[i]); end
         if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL full_data_%0d: data=%0h want %0h", i, got_data[i], exp_data[i]); end
      end
      repeat (6) step();
      total += 2;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL full_extra_rsp: rsp_valid=%b want 0", rsp_valid); end
      if (busy !== 1'b0)      begin bad++; $display("FAIL full_idle: busy=%b want 0", busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      push(1'b0, 2'd2, 8'd0);                        // R0
      push(1'b1, 2'd0, 8'h77);                       // queued behind the read
      step();
      step();                                        // R0+3
      total += 3;
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", rsp_valid); end
      if (rsp_data !== 8'h55) begin bad++; $display("FAIL bp_data: got %0h want 55", rsp_data); end
      if (rsp_sel !== 2'd2)   begin bad++; $display("FAIL bp_sel: got %0d want 2", rsp_sel); end
      for (int i = 0; i < 5; i++) begin
         step();
         total += 5;
         if (rsp_valid !== 1'b1)       begin bad++; $display("FAIL bp_hold_valid_%0d: got %b want 1", i, rsp_valid); end
         if (rsp_data !== 8'h55)       begin bad++; $display("FAIL bp_hold_data_%0d: got %0h want 55", i, rsp_data); end
         if (rsp_sel !== 2'd2)         begin bad++; $display("FAIL bp_hold_sel_%0d: got %0d want 2", i, rsp_sel); end
         if (rf_sel !== 2'd2)          begin bad++; $display("FAIL bp_no_pop_sel_%0d: got %0d want 2", i, rf_sel); end
         if (rf_data_in !== 8'hAA)     begin bad++; $display("FAIL bp_no_pop_data_%0d: got %0h want aa", i, rf_data_in); end
      end
      rsp_ready = 1'b1;
      step();                                        // handshake edge
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", rsp_valid); end
      step();                                        // queued write popped
      total += 2;
      if (rf_sel !== 2'd0)      begin bad++; $display("FAIL bp_next_sel: got %0d want 0", rf_sel); end
      if (rf_data_in !== 8'h77) begin bad++; $display("FAIL bp_next_data: got %0h want 77", rf_data_in); end
      wait_idle("bp_idle");
      total++; if (regs[0] !== 8'h77) begin bad++; $display("FAIL bp_rf_a: got %0h want 77", regs[0]); end
   endtask

   task automatic test_reset_mid_strobe();
      int s0;
      push(1'b1, 2'd1, 8'h99);                       // M0
      push(1'b1, 2'd2, 8'h11);                       // M1: first write popped
      push(1'b1, 2'd3, 8'h22);                       // M2: strobe low
      total++; if (rf_write_enable !== 1'b0) begin bad++; $display("FAIL mid_we_low: got %b want 0", rf_write_enable); end
      #2;
      reset_n = 1'b0;                                // between clock edges
      #1;
      s0 = strobes;
      total += 4;
      if (rf_write_enable !== 1'b1) begin bad++; $display("FAIL mid_we_async: got %b want 1", rf_write_enable); end
      if (busy !== 1'b0)            begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (cmd_ready !== 1'b1)       begin bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
      if (rf_sel !== 2'd0)          begin bad++; $display("FAIL mid_rf_sel: got %0d want 0", rf_sel); end
      repeat (2) step();
      reset_n = 1'b1;
      repeat (12) step();
      total += 5;
      if (strobes - s0 !== 0)  begin bad++; $display("FAIL mid_no_strobe: got %0d want 0", strobes - s0); end
      if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy_after: got %b want 0", busy); end
      if (regs[1] !== 8'h99)   begin bad++; $display("FAIL mid_rf_b: got %0h want 99", regs[1]); end
      if (regs[2] !== 8'h55)   begin bad++; $display("FAIL mid_rf_c: got %0h want 55", regs[2]); end
      if (regs[3] !== 8'hAA)   begin bad++; $display("FAIL mid_rf_d: got %0h want aa", regs[3]); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_after_write();
      test_fifo_full();
      test_backpressure();
      test_reset_mid_strobe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
